// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter that hands the VGA pixel port to one of NREQ drawing engines at a time.
// Each grant runs START -> WAIT_DONE -> RELEASE and is bounded by a TIMEOUT-cycle watchdog.
module vga_draw_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 131072
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*9-1:0] eng_x,
    input  logic [NREQ*8-1:0] eng_y,
    input  logic [NREQ*3-1:0] eng_colour,
    input  logic [NREQ-1:0]   eng_plot,
    input  logic [NREQ-1:0]   eng_done,
    output logic [NREQ-1:0]   eng_start,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   ack,
    output logic [8:0]        vga_x,
    output logic [7:0]        vga_y,
    output logic [2:0]        vga_colour,
    output logic              vga_plot,
    output logic              busy,
    output logic              timeout_err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_RELEASE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   w_owner_nxt;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   w_rr_ptr_nxt;
    logic [CW-1:0]   r_tcnt;
    logic [CW-1:0]   w_tcnt_nxt;
    logic            r_terr;
    logic            w_terr_nxt;
    logic            r_by_done;
    logic            w_by_done_nxt;

    logic [IW-1:0]   w_hi;
    logic            w_hi_vld;
    logic [IW-1:0]   w_lo;
    logic            w_lo_vld;
    logic [IW-1:0]   w_pick;
    logic            w_pick_vld;

    logic [NREQ-1:0] w_owner_oh;
    logic [8:0]      w_sel_x;
    logic [7:0]      w_sel_y;
    logic [2:0]      w_sel_colour;
    logic            w_sel_plot;
    logic            w_sel_done;
    logic            w_in_wait;
    logic            w_granted;

    // Round robin: first requester at or above the pointer, else the lowest requester (wrap).
    always_comb begin
        w_hi     = '0;
        w_hi_vld = 1'b0;
        w_lo     = '0;
        w_lo_vld = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!w_hi_vld && req[i] && (IW'(i) >= r_rr_ptr)) begin
                w_hi     = IW'(i);
                w_hi_vld = 1'b1;
            end
            if (!w_lo_vld && req[i]) begin
                w_lo     = IW'(i);
                w_lo_vld = 1'b1;
            end
        end
        w_pick     = w_hi_vld ? w_hi : w_lo;
        w_pick_vld = w_lo_vld;
    end

    always_comb begin
        w_owner_oh   = '0;
        w_sel_x      = '0;
        w_sel_y      = '0;
        w_sel_colour = '0;
        w_sel_plot   = 1'b0;
        w_sel_done   = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (r_owner == IW'(i)) begin
                w_owner_oh[i] = 1'b1;
                w_sel_x       = eng_x[i*9 +: 9];
                w_sel_y       = eng_y[i*8 +: 8];
                w_sel_colour  = eng_colour[i*3 +: 3];
                w_sel_plot    = eng_plot[i];
                w_sel_done    = eng_done[i];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            r_tcnt    <= '0;
            r_terr    <= 1'b0;
            r_by_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_terr    <= w_terr_nxt;
            r_by_done <= w_by_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_tcnt_nxt    = r_tcnt;
        w_terr_nxt    = r_terr;
        w_by_done_nxt = r_by_done;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_owner_nxt = w_pick;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tcnt_nxt  = '0;
                w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // Counter holds the number of WAIT_DONE cycles already spent; done beats timeout.
                if (w_sel_done) begin
                    w_by_done_nxt = 1'b1;
                    w_state_nxt   = S_RELEASE;
                end else if (r_tcnt == CW'(TIMEOUT - 1)) begin
                    w_by_done_nxt = 1'b0;
                    w_terr_nxt    = 1'b1;
                    w_state_nxt   = S_RELEASE;
                end else begin
                    w_tcnt_nxt = r_tcnt + CW'(1);
                end
            end
            S_RELEASE: begin
                w_rr_ptr_nxt  = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + IW'(1);
                w_by_done_nxt = 1'b0;
                w_state_nxt   = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_in_wait   = (r_state == S_WAIT_DONE);
        w_granted   = (r_state == S_START) || w_in_wait;
        busy        = (r_state != S_IDLE);
        grant       = w_granted ? w_owner_oh : '0;
        eng_start   = w_granted ? w_owner_oh : '0;
        ack         = ((r_state == S_RELEASE) && r_by_done) ? w_owner_oh : '0;
        vga_x       = w_in_wait ? w_sel_x : '0;
        vga_y       = w_in_wait ? w_sel_y : '0;
        vga_colour  = w_in_wait ? w_sel_colour : '0;
        vga_plot    = w_in_wait && w_sel_plot && (w_sel_x < 9'd320) && (w_sel_y < 8'd240);
        timeout_err = r_terr;
    end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Bench for vga_draw_arbiter: directed scenarios plus random traffic, all checked each cycle
// against a service-level reference model of the arbiter.
module tb_vga_draw_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [35:0] eng_x;
    logic [31:0] eng_y;
    logic [11:0] eng_colour;
    logic [3:0]  eng_plot;
    logic [3:0]  eng_done;
    logic [3:0]  eng_start;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    vga_draw_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .req        (req),
        .eng_x      (eng_x),
        .eng_y      (eng_y),
        .eng_colour (eng_colour),
        .eng_plot   (eng_plot),
        .eng_done   (eng_done),
        .eng_start  (eng_start),
        .grant      (grant),
        .ack        (ack),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a service is "not active", or active with an age (-1 = start cycle,
    // k >= 0 = k wait cycles already spent), then a single closing cycle.
    bit m_active, m_closing, m_closed_by_done, m_terr;
    int m_owner, m_age, m_ptr;

    // Observation log of the DUT, compared later against scenario constants.
    int cyc;
    int start_hi[4];
    int ack_seen[4];
    int g_idx_q[$];
    int g_cyc_q[$];
    logic [3:0] prev_grant;

    function automatic int rr_pick(input logic [3:0] r, input int ptr);
        int idx;
        for (int k = 0; k < NREQ; k++) begin
            idx = (ptr + k) % NREQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 0; m_closing = 0; m_closed_by_done = 0; m_terr = 0;
        m_owner = 0; m_age = 0; m_ptr = 0;
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 4; i++) begin
            start_hi[i] = 0;
            ack_seen[i] = 0;
        end
        g_idx_q.delete();
        g_cyc_q.delete();
        cyc = 0;
    endtask

    task automatic check_all();
        logic [3:0] eg, ea;
        logic [8:0] ex;
        logic [7:0] ey;
        logic [2:0] ec;
        logic       ep;
        bit         waiting;
        int         gi;
        waiting = m_active && !m_closing && (m_age >= 0);
        eg = (m_active && !m_closing) ? 4'(1 << m_owner) : 4'b0;
        ea = (m_active && m_closing && m_closed_by_done) ? 4'(1 << m_owner) : 4'b0;
        ex = '0; ey = '0; ec = '0; ep = 1'b0;
        if (waiting) begin
            ex = eng_x[m_owner*9 +: 9];
            ey = eng_y[m_owner*8 +: 8];
            ec = eng_colour[m_owner*3 +: 3];
            ep = eng_plot[m_owner] && (ex < 320) && (ey < 240);
        end
        check_eq("busy", busy, m_active);
        check_eq("grant", grant, eg);
        check_eq("eng_start", eng_start, eg);
        check_eq("ack", ack, ea);
        check_eq("vga_x", vga_x, ex);
        check_eq("vga_y", vga_y, ey);
        check_eq("vga_colour", vga_colour, ec);
        check_eq("vga_plot", vga_plot, ep);
        check_eq("timeout_err", timeout_err, m_terr);
        for (int i = 0; i < 4; i++) begin
            if (eng_start[i] === 1'b1) start_hi[i]++;
            if (ack[i] === 1'b1) ack_seen[i]++;
        end
        if (prev_grant == 4'b0 && grant != 4'b0) begin
            gi = -1;
            for (int i = 0; i < 4; i++) if (grant[i]) gi = i;
            g_idx_q.push_back(gi);
            g_cyc_q.push_back(cyc);
        end
        prev_grant = grant;
        cyc++;
    endtask

    task automatic model_update();
        int p;
        if (!m_active) begin
            p = rr_pick(req, m_ptr);
            if (p >= 0) begin
                m_active = 1; m_closing = 0; m_owner = p; m_age = -1;
            end
        end else if (m_closing) begin
            m_active  = 0;
            m_closing = 0;
            m_ptr     = (m_owner + 1) % NREQ;
        end else if (m_age < 0) begin
            m_age = 0;
        end else if (eng_done[m_owner]) begin
            m_closing = 1; m_closed_by_done = 1;
        end else if (m_age + 1 == TMO) begin
            m_closing = 1; m_closed_by_done = 0; m_terr = 1;
        end else begin
            m_age++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_ord[5];
        exp_ord = '{0, 1, 2, 3, 0};
        rst = 1'b1; req = '0; eng_x = '0; eng_y = '0; eng_colour = '0;
        eng_plot = '0; eng_done = '0; prev_grant = '0;
        model_reset();
        clear_obs();
        #3;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single engine: 10 wait cycles without done, done on the 11th.
        clear_obs();
        eng_x[8:0] = 9'd5; eng_y[7:0] = 8'd7; eng_colour[2:0] = 3'b111; eng_plot[0] = 1'b1;
        req = 4'b0001;
        tick();
        check_eq("a_start_now", eng_start, 4'b0001);
        check_eq("a_start_noplot", vga_plot, 1'b0);
        req = 4'b0000;
        tick();
        check_eq("a_px_x", vga_x, 9'd5);
        check_eq("a_px_y", vga_y, 8'd7);
        check_eq("a_px_c", vga_colour, 3'b111);
        check_eq("a_px_plot", vga_plot, 1'b1);
        repeat (10) tick();
        eng_done[0] = 1'b1;
        tick();
        eng_done[0] = 1'b0;
        check_eq("a_ack_now", ack, 4'b0001);
        tick();
        check_eq("a_busy_end", busy, 1'b0);
        check_eq("a_start_len", start_hi[0], 12);
        check_eq("a_ack_cnt", ack_seen[0], 1);
        eng_plot = '0;

        // All engines requesting and finishing immediately.
        pulse_reset();
        clear_obs();
        req = 4'b1111; eng_done = 4'b1111;
        repeat (18) tick();
        check_eq("b_ngrant", g_idx_q.size(), 5);
        for (int i = 0; i < 5 && i < g_idx_q.size(); i++) begin
            check_eq($sformatf("b_order%0d", i), g_idx_q[i], exp_ord[i]);
            if (i > 0) check_eq($sformatf("b_space%0d", i), g_cyc_q[i] - g_cyc_q[i-1], 4);
        end
        req = 4'b0000;
        repeat (2) tick();
        eng_done = 4'b0000;

        // Clipping on engine 1 (pointer is now 1).
        eng_x[17:9] = 9'd320; eng_y[15:8] = 8'd10; eng_colour[5:3] = 3'b101; eng_plot[1] = 1'b1;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        check_eq("c_clip_x", vga_x, 9'd320);
        check_eq("c_clip_plot", vga_plot, 1'b0);
        eng_x[17:9] = 9'd319;
        #1;
        check_eq("c_edge_plot", vga_plot, 1'b1);
        eng_y[15:8] = 8'd240;
        #1;
        check_eq("c_clip_y_plot", vga_plot, 1'b0);
        check_eq("c_clip_y", vga_y, 8'd240);
        eng_done[1] = 1'b1;
        tick();
        eng_done[1] = 1'b0;
        tick();
        eng_plot = '0;

        // Engine 2 never finishes; engine 3 waiting behind it.
        clear_obs();
        req = 4'b1100; eng_done = 4'b1000;
        tick();
        tick();
        repeat (15) tick();
        check_eq("d_still_busy", grant, 4'b0100);
        tick();
        check_eq("d_terr", timeout_err, 1'b1);
        check_eq("d_no_ack", ack, 4'b0000);
        check_eq("d_grant_off", grant, 4'b0000);
        tick();
        tick();
        check_eq("d_next_owner", grant, 4'b1000);
        check_eq("d_len", start_hi[2], 17);
        check_eq("d_ack_cnt", ack_seen[2], 0);
        req = 4'b0000;
        repeat (3) tick();
        eng_done = 4'b0000;

        // Non-owner plot must not reach the VGA port (pointer is now 0).
        eng_x[8:0] = 9'd10; eng_y[7:0] = 8'd20; eng_colour[2:0] = 3'd2;
        eng_x[17:9] = 9'd30; eng_y[15:8] = 8'd40; eng_colour[5:3] = 3'd5;
        eng_plot = 4'b0010;
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        check_eq("e_other_plot", vga_plot, 1'b0);
        check_eq("e_owner_x", vga_x, 9'd10);
        eng_plot = 4'b0011;
        #1;
        check_eq("e_both_plot", vga_plot, 1'b1);
        check_eq("e_colour", vga_colour, 3'd2);
        eng_done[0] = 1'b1;
        tick();
        eng_done[0] = 1'b0;
        tick();
        eng_plot = '0;

        // Asynchronous reset in the middle of a wait (pointer is now 1).
        req = 4'b0111;
        repeat (3) tick();
        check_eq("f_pre_grant", grant, 4'b0010);
        #2;
        rst = 1'b1;
        #1;
        check_eq("f_rst_busy", busy, 1'b0);
        check_eq("f_rst_grant", grant, 4'b0000);
        check_eq("f_rst_start", eng_start, 4'b0000);
        check_eq("f_rst_x", vga_x, 9'd0);
        check_eq("f_rst_terr", timeout_err, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check_eq("f_first_grant", grant, 4'b0001);
        req = 4'b0000; eng_done = 4'b0001;
        repeat (3) tick();
        eng_done = 4'b0000;

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            req        = 4'($urandom_range(0, 15));
            eng_x      = {4'($urandom), 32'($urandom)};
            eng_y      = 32'($urandom);
            eng_colour = 12'($urandom);
            eng_plot   = 4'($urandom);
            for (int i = 0; i < 4; i++) eng_done[i] = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
